// File: rtl/axi4_lite_pkg.sv
// Shared response codes and FSM state types for the AXI4-Lite register file.
package axi4_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    WrIdle,
    WrCommit,
    WrResp
  } wr_state_e;

  typedef enum logic {
    RdIdle,
    RdResp
  } rd_state_e;

endpackage

// File: rtl/axi4_lite_reg_decoder.sv
// Maps a byte address onto a register index and flags whether it hits the register window.
module axi4_lite_reg_decoder #(
  parameter int                     ADDRESS_WIDTH = 32,
  parameter int                     NUM_REGS      = 16,
  parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDRESS = '0,
  parameter int                     IDX_WIDTH     = $clog2(NUM_REGS)
) (
  input  logic [ADDRESS_WIDTH-1:0] addr,
  output logic                     in_range,
  output logic [IDX_WIDTH-1:0]     idx
);

  logic [ADDRESS_WIDTH-1:0] word_off;

  // Word offset from the base; the low two byte-address bits are dropped by the shift.
  always_comb begin
    word_off = (addr - BASE_ADDRESS) >> 2;
    in_range = (addr >= BASE_ADDRESS) && (word_off < ADDRESS_WIDTH'(NUM_REGS));
    idx      = word_off[IDX_WIDTH-1:0];
  end

endmodule

// File: rtl/axi4_lite_slave_regfile.sv
// AXI4-Lite responder holding NUM_REGS byte-writable registers, with per-register write pulses.
// Write and read paths are independent FSMs sharing only the register array.
module axi4_lite_slave_regfile
  import axi4_lite_pkg::*;
#(
  parameter int                     DATA_WIDTH    = 32,
  parameter int                     ADDRESS_WIDTH = 32,
  parameter int                     NUM_REGS      = 16,
  parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDRESS = 32'h0000_0000
) (
  input  logic                           aclk,
  input  logic                           aresetn,
  input  logic [ADDRESS_WIDTH-1:0]       s_axi_awaddr,
  input  logic                           s_axi_awvalid,
  output logic                           s_axi_awready,
  input  logic [DATA_WIDTH-1:0]          s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]        s_axi_wstrb,
  input  logic                           s_axi_wvalid,
  output logic                           s_axi_wready,
  output logic [1:0]                     s_axi_bresp,
  output logic                           s_axi_bvalid,
  input  logic                           s_axi_bready,
  input  logic [ADDRESS_WIDTH-1:0]       s_axi_araddr,
  input  logic                           s_axi_arvalid,
  output logic                           s_axi_arready,
  output logic [DATA_WIDTH-1:0]          s_axi_rdata,
  output logic [1:0]                     s_axi_rresp,
  output logic                           s_axi_rvalid,
  input  logic                           s_axi_rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_data,
  output logic [NUM_REGS-1:0]            reg_write_pulse
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int IDX_WIDTH  = $clog2(NUM_REGS);

  wr_state_e                           wr_state_q, wr_state_d;
  rd_state_e                           rd_state_q, rd_state_d;
  logic                                awready_q, awready_d;
  logic                                wready_q, wready_d;
  logic                                aw_have_q, aw_have_d;
  logic                                w_have_q, w_have_d;
  logic [IDX_WIDTH-1:0]                aw_idx_q, aw_idx_d;
  logic                                aw_in_range_q, aw_in_range_d;
  logic [DATA_WIDTH-1:0]               wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0]               wstrb_q, wstrb_d;
  logic                                bvalid_q, bvalid_d;
  logic [1:0]                          bresp_q, bresp_d;
  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_q, regs_d;
  logic [NUM_REGS-1:0]                 pulse_q, pulse_d;
  logic                                arready_q, arready_d;
  logic                                rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0]               rdata_q, rdata_d;
  logic [1:0]                          rresp_q, rresp_d;

  logic                                wr_in_range, rd_in_range;
  logic [IDX_WIDTH-1:0]                wr_idx, rd_idx;

  axi4_lite_reg_decoder #(
    .ADDRESS_WIDTH(ADDRESS_WIDTH),
    .NUM_REGS     (NUM_REGS),
    .BASE_ADDRESS (BASE_ADDRESS),
    .IDX_WIDTH    (IDX_WIDTH)
  ) u_aw_decoder (
    .addr    (s_axi_awaddr),
    .in_range(wr_in_range),
    .idx     (wr_idx)
  );

  axi4_lite_reg_decoder #(
    .ADDRESS_WIDTH(ADDRESS_WIDTH),
    .NUM_REGS     (NUM_REGS),
    .BASE_ADDRESS (BASE_ADDRESS),
    .IDX_WIDTH    (IDX_WIDTH)
  ) u_ar_decoder (
    .addr    (s_axi_araddr),
    .in_range(rd_in_range),
    .idx     (rd_idx)
  );

  // Next-state logic for both FSMs; reads sample regs_q so a same-cycle commit is not yet visible.
  always_comb begin
    wr_state_d    = wr_state_q;
    awready_d     = awready_q;
    wready_d      = wready_q;
    aw_have_d     = aw_have_q;
    w_have_d      = w_have_q;
    aw_idx_d      = aw_idx_q;
    aw_in_range_d = aw_in_range_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    bvalid_d      = bvalid_q;
    bresp_d       = bresp_q;
    regs_d        = regs_q;
    pulse_d       = '0;
    rd_state_d    = rd_state_q;
    arready_d     = arready_q;
    rvalid_d      = rvalid_q;
    rdata_d       = rdata_q;
    rresp_d       = rresp_q;

    unique case (wr_state_q)
      WrIdle: begin
        if (s_axi_awvalid && awready_q) begin
          aw_have_d     = 1'b1;
          aw_idx_d      = wr_idx;
          aw_in_range_d = wr_in_range;
        end
        if (s_axi_wvalid && wready_q) begin
          w_have_d = 1'b1;
          wdata_d  = s_axi_wdata;
          wstrb_d  = s_axi_wstrb;
        end
        awready_d = !aw_have_d;
        wready_d  = !w_have_d;
        if (aw_have_d && w_have_d) begin
          aw_have_d  = 1'b0;
          w_have_d   = 1'b0;
          wr_state_d = WrCommit;
        end
      end
      WrCommit: begin
        if (aw_in_range_q) begin
          for (int k = 0; k < STRB_WIDTH; k++) begin
            if (wstrb_q[k]) begin
              regs_d[aw_idx_q][k*8 +: 8] = wdata_q[k*8 +: 8];
            end
          end
          pulse_d[aw_idx_q] = 1'b1;
          bresp_d           = RESP_OKAY;
        end else begin
          bresp_d = RESP_DECERR;
        end
        bvalid_d   = 1'b1;
        wr_state_d = WrResp;
      end
      WrResp: begin
        if (bvalid_q && s_axi_bready) begin
          bvalid_d   = 1'b0;
          bresp_d    = RESP_OKAY;
          awready_d  = 1'b1;
          wready_d   = 1'b1;
          wr_state_d = WrIdle;
        end
      end
      default: begin
        wr_state_d = WrIdle;
        awready_d  = 1'b0;
        wready_d   = 1'b0;
        aw_have_d  = 1'b0;
        w_have_d   = 1'b0;
        bvalid_d   = 1'b0;
        bresp_d    = RESP_OKAY;
      end
    endcase

    unique case (rd_state_q)
      RdIdle: begin
        arready_d = 1'b1;
        if (s_axi_arvalid && arready_q) begin
          arready_d  = 1'b0;
          rvalid_d   = 1'b1;
          rdata_d    = rd_in_range ? regs_q[rd_idx] : '0;
          rresp_d    = rd_in_range ? RESP_OKAY : RESP_DECERR;
          rd_state_d = RdResp;
        end
      end
      RdResp: begin
        if (rvalid_q && s_axi_rready) begin
          rvalid_d   = 1'b0;
          rdata_d    = '0;
          rresp_d    = RESP_OKAY;
          arready_d  = 1'b1;
          rd_state_d = RdIdle;
        end
      end
      default: begin
        rd_state_d = RdIdle;
        arready_d  = 1'b0;
        rvalid_d   = 1'b0;
        rdata_d    = '0;
        rresp_d    = RESP_OKAY;
      end
    endcase
  end

  // State register; reset clears everything, readies come up on the first edge after release.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_state_q    <= WrIdle;
      rd_state_q    <= RdIdle;
      awready_q     <= 1'b0;
      wready_q      <= 1'b0;
      aw_have_q     <= 1'b0;
      w_have_q      <= 1'b0;
      aw_idx_q      <= '0;
      aw_in_range_q <= 1'b0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      bvalid_q      <= 1'b0;
      bresp_q       <= RESP_OKAY;
      regs_q        <= '0;
      pulse_q       <= '0;
      arready_q     <= 1'b0;
      rvalid_q      <= 1'b0;
      rdata_q       <= '0;
      rresp_q       <= RESP_OKAY;
    end else begin
      wr_state_q    <= wr_state_d;
      rd_state_q    <= rd_state_d;
      awready_q     <= awready_d;
      wready_q      <= wready_d;
      aw_have_q     <= aw_have_d;
      w_have_q      <= w_have_d;
      aw_idx_q      <= aw_idx_d;
      aw_in_range_q <= aw_in_range_d;
      wdata_q       <= wdata_d;
      wstrb_q       <= wstrb_d;
      bvalid_q      <= bvalid_d;
      bresp_q       <= bresp_d;
      regs_q        <= regs_d;
      pulse_q       <= pulse_d;
      arready_q     <= arready_d;
      rvalid_q      <= rvalid_d;
      rdata_q       <= rdata_d;
      rresp_q       <= rresp_d;
    end
  end

  assign s_axi_awready   = awready_q;
  assign s_axi_wready    = wready_q;
  assign s_axi_bvalid    = bvalid_q;
  assign s_axi_bresp     = bresp_q;
  assign s_axi_arready   = arready_q;
  assign s_axi_rvalid    = rvalid_q;
  assign s_axi_rdata     = rdata_q;
  assign s_axi_rresp     = rresp_q;
  assign reg_data        = regs_q;
  assign reg_write_pulse = pulse_q;

endmodule

// File: tb/tb_axi4_lite_slave_regfile.sv
// Directed self-checking bench for axi4_lite_slave_regfile with default parameters.
module tb_axi4_lite_slave_regfile;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic [31:0]   s_axi_awaddr;
  logic          s_axi_awvalid;
  logic          s_axi_awready;
  logic [31:0]   s_axi_wdata;
  logic [3:0]    s_axi_wstrb;
  logic          s_axi_wvalid;
  logic          s_axi_wready;
  logic [1:0]    s_axi_bresp;
  logic          s_axi_bvalid;
  logic          s_axi_bready;
  logic [31:0]   s_axi_araddr;
  logic          s_axi_arvalid;
  logic          s_axi_arready;
  logic [31:0]   s_axi_rdata;
  logic [1:0]    s_axi_rresp;
  logic          s_axi_rvalid;
  logic          s_axi_rready;
  logic [511:0]  reg_data;
  logic [15:0]   reg_write_pulse;

  int            tests_run    = 0;
  int            tests_failed = 0;
  logic [31:0]   exp_regs [16];

  always #5 aclk = ~aclk;

  axi4_lite_slave_regfile dut (
    .aclk           (aclk),
    .aresetn        (aresetn),
    .s_axi_awaddr   (s_axi_awaddr),
    .s_axi_awvalid  (s_axi_awvalid),
    .s_axi_awready  (s_axi_awready),
    .s_axi_wdata    (s_axi_wdata),
    .s_axi_wstrb    (s_axi_wstrb),
    .s_axi_wvalid   (s_axi_wvalid),
    .s_axi_wready   (s_axi_wready),
    .s_axi_bresp    (s_axi_bresp),
    .s_axi_bvalid   (s_axi_bvalid),
    .s_axi_bready   (s_axi_bready),
    .s_axi_araddr   (s_axi_araddr),
    .s_axi_arvalid  (s_axi_arvalid),
    .s_axi_arready  (s_axi_arready),
    .s_axi_rdata    (s_axi_rdata),
    .s_axi_rresp    (s_axi_rresp),
    .s_axi_rvalid   (s_axi_rvalid),
    .s_axi_rready   (s_axi_rready),
    .reg_data       (reg_data),
    .reg_write_pulse(reg_write_pulse)
  );

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge aclk);
    #1;
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 16; i++) begin
      checkOutput($sformatf("%s_reg%0d", tag, i), reg_data[i*32 +: 32], exp_regs[i]);
    end
  endtask

  // Bench-side register model: byte-enable update for in-window addresses only.
  task automatic model_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    if (addr < 32'h40) begin
      for (int k = 0; k < 4; k++) begin
        if (strb[k]) exp_regs[addr[5:2]][k*8 +: 8] = data[k*8 +: 8];
      end
    end
  endtask

  // W is presented at once; AW follows aw_delay cycles later. hold = cycles bready stays low.
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_delay, input int hold, input logic [1:0] exp_resp,
                          input logic [15:0] exp_pulse);
    logic aw_pend, w_pend, aw_hs, w_hs;
    int   cyc;
    aw_pend       = 1'b1;
    w_pend        = 1'b1;
    cyc           = 0;
    s_axi_awaddr  = addr;
    s_axi_wdata   = data;
    s_axi_wstrb   = strb;
    s_axi_wvalid  = 1'b1;
    s_axi_awvalid = (aw_delay == 0);
    while ((aw_pend || w_pend) && cyc < 20) begin
      aw_hs = s_axi_awvalid && s_axi_awready;
      w_hs  = s_axi_wvalid && s_axi_wready;
      next_cycle();
      cyc++;
      if (aw_hs) begin
        s_axi_awvalid = 1'b0;
        aw_pend       = 1'b0;
      end
      if (w_hs) begin
        s_axi_wvalid = 1'b0;
        w_pend       = 1'b0;
        if (aw_pend) checkOutput("wready_drop", 32'(s_axi_wready), 32'd0);
      end
      if (aw_pend && cyc >= aw_delay) s_axi_awvalid = 1'b1;
    end
    if (aw_pend || w_pend) begin
      checkOutput("aw_w_timeout", 32'(aw_pend | w_pend), 32'd0);
      s_axi_awvalid = 1'b0;
      s_axi_wvalid  = 1'b0;
    end
    cyc = 0;
    while (!s_axi_bvalid && cyc < 20) begin
      next_cycle();
      cyc++;
    end
    checkOutput("bvalid", 32'(s_axi_bvalid), 32'd1);
    checkOutput("bresp", 32'(s_axi_bresp), 32'(exp_resp));
    checkOutput("pulse", 32'(reg_write_pulse), 32'(exp_pulse));
    for (int h = 0; h < hold; h++) begin
      next_cycle();
      checkOutput("bvalid_hold", 32'(s_axi_bvalid), 32'd1);
      checkOutput("bresp_hold", 32'(s_axi_bresp), 32'(exp_resp));
      checkOutput("awready_hold", 32'(s_axi_awready), 32'd0);
    end
    s_axi_bready = 1'b1;
    next_cycle();
    s_axi_bready = 1'b0;
    checkOutput("bvalid_drop", 32'(s_axi_bvalid), 32'd0);
    checkOutput("pulse_one_cycle", 32'(reg_write_pulse), 32'd0);
    checkOutput("awready_back", 32'(s_axi_awready), 32'd1);
    checkOutput("wready_back", 32'(s_axi_wready), 32'd1);
    model_write(addr, data, strb);
  endtask

  // Single read; hold = cycles rready stays low after rvalid.
  task automatic do_read(input logic [31:0] addr, input int hold,
                         input logic [31:0] exp_data, input logic [1:0] exp_resp);
    logic hs, done;
    int   cyc;
    done          = 1'b0;
    cyc           = 0;
    s_axi_araddr  = addr;
    s_axi_arvalid = 1'b1;
    while (!done && cyc < 20) begin
      hs = s_axi_arvalid && s_axi_arready;
      next_cycle();
      cyc++;
      if (hs) begin
        s_axi_arvalid = 1'b0;
        done          = 1'b1;
      end
    end
    if (!done) begin
      checkOutput("ar_timeout", 32'(done), 32'd1);
      s_axi_arvalid = 1'b0;
    end
    checkOutput("rvalid_lat1", 32'(s_axi_rvalid), 32'd1);
    checkOutput("rdata", s_axi_rdata, exp_data);
    checkOutput("rresp", 32'(s_axi_rresp), 32'(exp_resp));
    for (int h = 0; h < hold; h++) begin
      next_cycle();
      checkOutput("rvalid_hold", 32'(s_axi_rvalid), 32'd1);
      checkOutput("rdata_hold", s_axi_rdata, exp_data);
      checkOutput("rresp_hold", 32'(s_axi_rresp), 32'(exp_resp));
      checkOutput("arready_hold", 32'(s_axi_arready), 32'd0);
    end
    s_axi_rready = 1'b1;
    next_cycle();
    s_axi_rready = 1'b0;
    checkOutput("rvalid_drop", 32'(s_axi_rvalid), 32'd0);
    checkOutput("arready_back", 32'(s_axi_arready), 32'd1);
  endtask

  initial begin
    aresetn       = 1'b0;
    s_axi_awaddr  = '0;
    s_axi_awvalid = 1'b0;
    s_axi_wdata   = '0;
    s_axi_wstrb   = '0;
    s_axi_wvalid  = 1'b0;
    s_axi_bready  = 1'b0;
    s_axi_araddr  = '0;
    s_axi_arvalid = 1'b0;
    s_axi_rready  = 1'b0;
    for (int i = 0; i < 16; i++) exp_regs[i] = '0;

    // Reset state, then readies rise on the first edge after release
    repeat (3) @(posedge aclk);
    #1;
    checkOutput("rst_awready", 32'(s_axi_awready), 32'd0);
    checkOutput("rst_wready", 32'(s_axi_wready), 32'd0);
    checkOutput("rst_arready", 32'(s_axi_arready), 32'd0);
    checkOutput("rst_bvalid", 32'(s_axi_bvalid), 32'd0);
    checkOutput("rst_rvalid", 32'(s_axi_rvalid), 32'd0);
    checkOutput("rst_pulse", 32'(reg_write_pulse), 32'd0);
    check_regs("rst");
    aresetn = 1'b1;
    #1;
    checkOutput("rel_awready_pre", 32'(s_axi_awready), 32'd0);
    next_cycle();
    checkOutput("rel_awready", 32'(s_axi_awready), 32'd1);
    checkOutput("rel_wready", 32'(s_axi_wready), 32'd1);
    checkOutput("rel_arready", 32'(s_axi_arready), 32'd1);

    // AW and W in the same cycle
    do_write(32'h4, 32'hDEAD_BEEF, 4'hF, 0, 0, 2'b00, 16'h0002);
    checkOutput("reg1_literal", reg_data[1*32 +: 32], 32'hDEAD_BEEF);

    // W two cycles ahead of AW, partial strobes over an all-ones register
    do_write(32'h8, 32'hFFFF_FFFF, 4'hF, 0, 0, 2'b00, 16'h0004);
    do_write(32'h8, 32'h1122_3344, 4'b0101, 2, 0, 2'b00, 16'h0004);
    checkOutput("reg2_literal", reg_data[2*32 +: 32], 32'hFF22_FF44);

    // Out-of-range write and read with response backpressure
    do_write(32'h40, 32'h1234_5678, 4'hF, 0, 5, 2'b11, 16'h0000);
    check_regs("oor");
    do_read(32'h40, 5, 32'h0, 2'b11);
    do_read(32'h4, 0, 32'hDEAD_BEEF, 2'b00);
    do_read(32'h9, 0, 32'hFF22_FF44, 2'b00);

    // AR handshake in the WrCommit cycle sees the old contents
    s_axi_awaddr  = 32'hC;
    s_axi_wdata   = 32'hA5A5_A5A5;
    s_axi_wstrb   = 4'hF;
    s_axi_awvalid = 1'b1;
    s_axi_wvalid  = 1'b1;
    next_cycle();
    s_axi_awvalid = 1'b0;
    s_axi_wvalid  = 1'b0;
    checkOutput("col_awready_low", 32'(s_axi_awready), 32'd0);
    checkOutput("col_arready", 32'(s_axi_arready), 32'd1);
    s_axi_araddr  = 32'hC;
    s_axi_arvalid = 1'b1;
    next_cycle();
    s_axi_arvalid = 1'b0;
    checkOutput("col_rvalid", 32'(s_axi_rvalid), 32'd1);
    checkOutput("col_rdata_old", s_axi_rdata, 32'h0);
    checkOutput("col_bvalid", 32'(s_axi_bvalid), 32'd1);
    checkOutput("col_reg3_new", reg_data[3*32 +: 32], 32'hA5A5_A5A5);
    s_axi_bready = 1'b1;
    s_axi_rready = 1'b1;
    next_cycle();
    s_axi_bready = 1'b0;
    s_axi_rready = 1'b0;
    checkOutput("col_bvalid_drop", 32'(s_axi_bvalid), 32'd0);
    checkOutput("col_rvalid_drop", 32'(s_axi_rvalid), 32'd0);
    exp_regs[3] = 32'hA5A5_A5A5;
    do_read(32'hC, 0, 32'hA5A5_A5A5, 2'b00);

    // Reset while a B beat is pending
    s_axi_awaddr  = 32'h14;
    s_axi_wdata   = 32'h55AA_55AA;
    s_axi_wstrb   = 4'hF;
    s_axi_awvalid = 1'b1;
    s_axi_wvalid  = 1'b1;
    next_cycle();
    s_axi_awvalid = 1'b0;
    s_axi_wvalid  = 1'b0;
    next_cycle();
    checkOutput("pre_rst_bvalid", 32'(s_axi_bvalid), 32'd1);
    #1;
    aresetn = 1'b0;
    #1;
    checkOutput("mid_rst_bvalid", 32'(s_axi_bvalid), 32'd0);
    checkOutput("mid_rst_awready", 32'(s_axi_awready), 32'd0);
    checkOutput("mid_rst_arready", 32'(s_axi_arready), 32'd0);
    for (int i = 0; i < 16; i++) exp_regs[i] = '0;
    check_regs("mid_rst");
    next_cycle();
    aresetn = 1'b1;
    checkOutput("rel2_awready_pre", 32'(s_axi_awready), 32'd0);
    next_cycle();
    checkOutput("rel2_awready", 32'(s_axi_awready), 32'd1);
    checkOutput("rel2_wready", 32'(s_axi_wready), 32'd1);
    checkOutput("rel2_arready", 32'(s_axi_arready), 32'd1);
    checkOutput("rel2_bvalid", 32'(s_axi_bvalid), 32'd0);
    next_cycle();
    checkOutput("no_stale_b", 32'(s_axi_bvalid), 32'd0);
    do_read(32'h4, 0, 32'h0, 2'b00);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Backstop in case a handshake never completes.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
